// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : alu_pkg
//  Purpose  : Shared opcode encoding and default datapath width for the ALU.
//  Revision : 1.0 - initial release
// ============================================================================
package alu_pkg;

  localparam int DEFAULT_WIDTH = 4;

  // Opcode encoding; all eight codes are meaningful.
  typedef enum logic [2:0] {
    OP_ADD = 3'b000,
    OP_SUB = 3'b001,
    OP_AND = 3'b010,
    OP_OR  = 3'b011,
    OP_XOR = 3'b100,
    OP_NOT = 3'b101,
    OP_SHL = 3'b110,
    OP_SHR = 3'b111
  } alu_op_t;

endpackage : alu_pkg
`default_nettype wire

// File: rtl/alu_core.sv
`default_nettype none
// ============================================================================
//  Module   : alu_core
//  Purpose  : Combinational ALU function: next result and carry/borrow/
//             shift-out bit from two operands and an opcode.
//  Revision : 1.0 - initial release
// ============================================================================
module alu_core
  import alu_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic [2:0]       i_sel,
  output logic [WIDTH-1:0] o_result,
  output logic             o_carry
);

  logic [WIDTH:0] w_sum;
  logic [WIDTH:0] w_diff;

  // Extended-width add/subtract; the top bit is carry or borrow respectively.
  always_comb begin
    w_sum  = {1'b0, i_a} + {1'b0, i_b};
    w_diff = {1'b0, i_a} - {1'b0, i_b};
  end

  // Opcode decode; the default arm keeps the outputs at a known 0/0.
  always_comb begin
    o_result = '0;
    o_carry  = 1'b0;
    case (alu_op_t'(i_sel))
      OP_ADD: begin
        o_result = w_sum[WIDTH-1:0];
        o_carry  = w_sum[WIDTH];
      end
      OP_SUB: begin
        o_result = w_diff[WIDTH-1:0];
        o_carry  = w_diff[WIDTH];
      end
      OP_AND: o_result = i_a & i_b;
      OP_OR:  o_result = i_a | i_b;
      OP_XOR: o_result = i_a ^ i_b;
      OP_NOT: o_result = ~i_a;
      OP_SHL: begin
        o_result = {i_a[WIDTH-2:0], 1'b0};
        o_carry  = i_a[WIDTH-1];
      end
      OP_SHR: begin
        o_result = {1'b0, i_a[WIDTH-1:1]};
        o_carry  = i_a[0];
      end
      default: begin
        o_result = '0;
        o_carry  = 1'b0;
      end
    endcase
  end

endmodule : alu_core
`default_nettype wire

// File: rtl/alu.sv
`default_nettype none
// ============================================================================
//  Module   : alu
//  Purpose  : Registered ALU execute stage, one-cycle latency, new operation
//             accepted every cycle, synchronous active-high reset.
//  Revision : 1.0 - initial release
// ============================================================================
module alu
  import alu_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [2:0]       SEL,
  output logic [WIDTH-1:0] RESULT,
  output logic             CARRY
);

  logic [WIDTH-1:0] w_next_result;
  logic             w_next_carry;
  logic [WIDTH-1:0] result_d;
  logic [WIDTH-1:0] result_q;
  logic             carry_d;
  logic             carry_q;

  alu_core #(
    .WIDTH (WIDTH)
  ) u_core (
    .i_a      (A),
    .i_b      (B),
    .i_sel    (SEL),
    .o_result (w_next_result),
    .o_carry  (w_next_carry)
  );

  // Next-state values are simply the combinational ALU outputs.
  always_comb begin
    result_d = w_next_result;
    carry_d  = w_next_carry;
  end

  // Output register; reset takes priority over the operation in that cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      result_q <= '0;
      carry_q  <= 1'b0;
    end else begin
      result_q <= result_d;
      carry_q  <= carry_d;
    end
  end

  assign RESULT = result_q;
  assign CARRY  = carry_q;

endmodule : alu
`default_nettype wire

// File: tb/tb_alu.sv
`default_nettype none
// ============================================================================
//  Module   : tb_alu
//  Purpose  : Self-checking bench for alu: directed cases plus random
//             back-to-back operations against an arithmetic reference model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_alu;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic [2:0]   sel;
  logic [W-1:0] result;
  logic         carry;

  int checks = 0;
  int errors = 0;

  logic [4:0] prev_exp;
  bit         have_prev = 1'b0;

  alu #(.WIDTH(W)) dut (
    .clk    (clk),
    .rst    (rst),
    .A      (a),
    .B      (b),
    .SEL    (sel),
    .RESULT (result),
    .CARRY  (carry)
  );

  always #5 clk = ~clk;

  // Compare {carry,result} against the expected value and log any mismatch.
  task automatic check_eq(input string tag, input logic [4:0] got, input logic [4:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got carry=%b result=%b, expected carry=%b result=%b",
               tag, got[4], got[3:0], exp[4], exp[3:0]);
    end
  endtask

  // Reference model from plain integer arithmetic; returns {carry,result}.
  function automatic logic [4:0] model(input int ai, input int bi, input int op);
    int r;
    int c;
    r = 0;
    c = 0;
    case (op)
      0: begin r = ai + bi; c = (r >= 16) ? 1 : 0; r = r % 16; end
      1: begin r = (ai - bi + 16) % 16; c = (ai < bi) ? 1 : 0; end
      2: r = ai & bi;
      3: r = ai | bi;
      4: r = ai ^ bi;
      5: r = 15 - ai;
      6: begin r = (ai * 2) % 16; c = (ai >= 8) ? 1 : 0; end
      7: begin r = ai / 2; c = ai % 2; end
      default: begin r = 0; c = 0; end
    endcase
    model = {c[0], r[3:0]};
  endfunction

  // Apply one operation at the falling edge, confirm the outputs did not
  // follow the new inputs, then check the registered result after the edge.
  task automatic step(input bit r_in, input int ai, input int bi, input int op, input string tag);
    logic [4:0] exp;
    @(negedge clk);
    rst = r_in;
    a   = ai[3:0];
    b   = bi[3:0];
    sel = op[2:0];
    exp = r_in ? 5'b0 : model(ai, bi, op);
    #2;
    if (have_prev) check_eq({tag, "_hold"}, {carry, result}, prev_exp);
    @(posedge clk);
    #1;
    check_eq(tag, {carry, result}, exp);
    prev_exp  = exp;
    have_prev = 1'b1;
  endtask

  initial begin
    rst = 1'b1;
    a   = '0;
    b   = '0;
    sel = '0;

    // Reset with active-looking inputs, held for two edges.
    step(1'b1, 15, 15, 0, "rst1");
    step(1'b1, 15, 15, 0, "rst2");
    step(1'b0, 15, 15, 0, "post_rst_add");

    // Arithmetic.
    step(1'b0, 4'b0011, 4'b0101, 0, "add_3_5");
    step(1'b0, 4'b1001, 4'b0010, 1, "sub_9_2");
    step(1'b0, 4'b1111, 4'b0001, 0, "add_wrap");
    step(1'b0, 4'b0010, 4'b0101, 1, "sub_borrow");
    step(1'b0, 4'b0110, 4'b0110, 1, "sub_equal");
    step(1'b0, 4'b0000, 4'b0001, 1, "sub_0_1");

    // Logic.
    step(1'b0, 4'b1100, 4'b1010, 2, "and");
    step(1'b0, 4'b1100, 4'b1010, 3, "or");
    step(1'b0, 4'b1100, 4'b1010, 4, "xor");
    step(1'b0, 4'b1100, 4'b1010, 5, "not");

    // Shifts.
    step(1'b0, 4'b0011, 4'b1111, 6, "shl_0011");
    step(1'b0, 4'b1010, 4'b1111, 7, "shr_1010");
    step(1'b0, 4'b1001, 4'b0000, 6, "shl_1001");
    step(1'b0, 4'b1001, 4'b0000, 7, "shr_1001");

    // Back-to-back sweep over all opcodes, then random traffic with
    // occasional mid-stream reset.
    for (int op = 0; op < 8; op++) begin
      step(1'b0, 4'b1011, 4'b0110, op, "sweep");
    end
    for (int i = 0; i < 200; i++) begin
      step(($urandom_range(0, 11) == 0), $urandom_range(0, 15),
           $urandom_range(0, 15), $urandom_range(0, 7), "rand");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_alu
`default_nettype wire

// File: doc/alu.md
Name: alu

Overview:
- Registered 4-bit arithmetic/logic unit: two operands and a 3-bit opcode in; one result plus a carry/borrow/shift-out flag out.
- Used as the datapath execute stage of small controllers.
- Inputs are sampled on every rising clock edge; outputs are registered, so latency is 1 cycle.

Parameters:
- WIDTH, 4, operand/result width in bits (all behaviour below is written for WIDTH=4 and generalises bitwise).

Ports:
- clk  input  1  single system clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- A  input  WIDTH  operand A.
- B  input  WIDTH  operand B (ignored by unary ops).
- SEL  input  3  opcode.
- RESULT  output  WIDTH  registered operation result.
- CARRY  output  1  registered carry/borrow/shifted-out bit.

Behaviour:
- Reset: on a rising clk edge with rst=1, RESULT<=0 and CARRY<=0, regardless of A/B/SEL. Reset wins over any operation in that cycle.
- Normal operation: on each rising clk edge with rst=0, RESULT and CARRY load f(A,B,SEL) computed from the values present at that edge. No enable, no handshake; a new op is accepted every cycle.
- Outputs hold between edges; combinational input changes are not visible until the next edge.
- Opcodes (results truncated to WIDTH bits):
  - 000 ADD: {CARRY,RESULT} = A + B (unsigned, WIDTH+1 bits).
  - 001 SUB: RESULT = A - B mod 2^WIDTH. CARRY = borrow = 1 iff A < B unsigned.
  - 010 AND: RESULT = A & B; CARRY = 0.
  - 011 OR: RESULT = A | B; CARRY = 0.
  - 100 XOR: RESULT = A ^ B; CARRY = 0.
  - 101 NOT: RESULT = ~A; B ignored; CARRY = 0.
  - 110 SHL: RESULT = A << 1 with 0 shifted in; CARRY = A[WIDTH-1]; B ignored.
  - 111 SHR: RESULT = A >> 1 with 0 shifted in (logical); CARRY = A[0]; B ignored.
- All 8 codes are defined; there is no illegal opcode.
- No X propagation from the datapath; the default branch maps to 0/0.
- Boundary cases:
  - ADD 1111+0001 -> 0000, CARRY=1.
  - SUB equal operands -> 0000, CARRY=0.
  - SUB 0000-0001 -> 1111, CARRY=1.
- Reset asserted mid-stream: the next edge clears the outputs. The first edge after deassertion produces the result of the inputs present at that edge.

Decomposition:
- Shared package alu_pkg:
  - SEL encoding constants (OP_ADD=3'b000 … OP_SHR=3'b111), or a 3-bit enum typedef alu_op_t.
  - Default WIDTH constant.
- One natural sub-module, alu_core: purely combinational, computes next_result/next_carry from A, B, SEL.
- Top alu holds only the output register and the synchronous reset.

Test Plan:
- Reset: drive A=1111, B=1111, SEL=000 with rst=1 for 2 edges -> RESULT=0000, CARRY=0. Deassert; next edge -> RESULT=1110, CARRY=1.
- Arithmetic, one cycle after applying each:
  - A=0011, B=0101, ADD -> 1000/0.
  - A=1001, B=0010, SUB -> 0111/0.
  - A=1111, B=0001, ADD -> 0000/1.
  - A=0010, B=0101, SUB -> 1101/1.
- Logic with A=1100, B=1010:
  - AND -> 1000/0.
  - OR -> 1110/0.
  - XOR -> 0110/0.
  - Then A=1100, NOT -> 0011/0.
- Shifts:
  - A=0011, SHL -> 0110/0.
  - A=1010, SHR -> 0101/0.
  - A=1001, SHL -> 0010/1.
  - A=1001, SHR -> 0100/1.
- Latency/back-to-back: change op every cycle across all 8 opcodes. Each output equals the op sampled exactly one edge earlier, and outputs never change between edges.
